// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: data width, opcodes, FSM states, response record.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package alu_pkg;

  localparam int DW = 16;

  // Opcode map. 4'b0000 and anything above OP_MAX are accepted but flagged as errors.
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_NOT = 4'd6,  // ~a
    OP_SLL = 4'd7,  // a << b[3:0]
    OP_SRL = 4'd8,  // a >> b[3:0], zero fill
    OP_SRA = 4'd9   // a >>> b[3:0], sign fill
  } alu_op_e;

  localparam logic [3:0] OP_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DW-1:0] result;
    logic          neg;
    logic          zero;
    logic          overflow;
    logic          err;
  } rsp_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op != OP_NOP) && (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU: result plus negative/zero/signed-overflow flags.
// Latency: 0 cycles (pure combinational); the caller registers inputs and outputs.
// Backpressure: none.
// Ports: op (4b opcode), a/b (operands) -> result, neg, zero, overflow.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          neg,
  output logic          zero,
  output logic          overflow
);

  logic [3:0] shamt;
  assign shamt = b[3:0];

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result   = a + b;
        // Signed overflow: same-sign operands produce an opposite-sign sum.
        overflow = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        result   = a - b;
        overflow = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $signed(a) >>> shamt;
      default: result = '0;
    endcase
  end

  assign neg  = result[DW-1];
  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters, one operation in flight, round-robin grant on contention.
// Latency: accept at edge N, response valid after edge N+1, held until the owner's rspn_ready.
// Backpressure: reqn_ready only in IDLE; a stalled response blocks all new accepts.
// Ports: clk/reset (sync, active-high); reqn_valid/op/a/b/ready and rspn_valid/ready per requester;
//        shared rsp_result/neg/zero/overflow/err bus; busy high whenever not IDLE.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [3:0]    req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  output logic          req0_ready,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  input  logic          req1_valid,
  input  logic [3:0]    req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          req1_ready,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp_result,
  output logic          rsp_neg,
  output logic          rsp_zero,
  output logic          rsp_overflow,
  output logic          rsp_err,
  output logic          busy
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;   // requester that owns the in-flight operation
  logic          prio_q,  prio_d;    // requester that wins when both are valid
  logic [3:0]    op_q,    op_d;
  logic [DW-1:0] a_q,     a_d;
  logic [DW-1:0] b_q,     b_d;
  rsp_t          rsp_q,   rsp_d;

  logic [DW-1:0] alu_result;
  logic          alu_neg, alu_zero, alu_overflow;

  logic idle, grant1, accept0, accept1, owner_rdy;

  // Readies are suppressed while reset is high so nothing looks accepted on a reset edge.
  assign idle    = (state_q == ST_IDLE) && !reset;
  assign grant1  = req1_valid && (!req0_valid || prio_q);
  assign accept0 = idle && req0_valid && !grant1;
  assign accept1 = idle && grant1;

  assign req0_ready = accept0;
  assign req1_ready = accept1;

  assign owner_rdy = owner_q ? rsp1_ready : rsp0_ready;

  alu u_alu (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (alu_result),
    .neg      (alu_neg),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rsp_d   = rsp_q;
    case (state_q)
      ST_IDLE: begin
        if (accept0 || accept1) begin
          state_d = ST_EXEC;
          owner_d = accept1;
          prio_d  = !accept1;   // the requester not just served wins the next tie
          op_d    = accept1 ? req1_op : req0_op;
          a_d     = accept1 ? req1_a  : req0_a;
          b_d     = accept1 ? req1_b  : req0_b;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
        if (op_legal(op_q)) begin
          rsp_d.result   = alu_result;
          rsp_d.neg      = alu_neg;
          rsp_d.zero     = alu_zero;
          rsp_d.overflow = alu_overflow;
          rsp_d.err      = 1'b0;
        end else begin
          rsp_d.result   = '0;
          rsp_d.neg      = 1'b0;
          rsp_d.zero     = 1'b1;
          rsp_d.overflow = 1'b0;
          rsp_d.err      = 1'b1;
        end
      end
      ST_RESP: begin
        if (owner_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rsp_q   <= rsp_d;
    end
  end

  assign rsp0_valid   = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid   = (state_q == ST_RESP) &&  owner_q;
  assign busy         = (state_q != ST_IDLE);
  assign rsp_result   = rsp_q.result;
  assign rsp_neg      = rsp_q.neg;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_err      = rsp_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios then random traffic vs a transaction model.
// Latency: n/a.
// Backpressure: random rspn_ready drives response stalls.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [15:0] rsp_result;
  logic        rsp_neg, rsp_zero, rsp_overflow, rsp_err;
  logic        busy;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_neg(rsp_neg), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus staging, applied at the next falling edge by step().
  logic        s_v[2];
  logic [3:0]  s_op[2];
  logic [15:0] s_a[2];
  logic [15:0] s_b[2];
  logic        s_rr[2];
  logic        s_rst;

  // Transaction-level model: one op in flight, age counts edges since its accept.
  int          m_active = 0;
  int          m_owner  = 0;
  int          m_age    = 0;
  int          m_prio   = 0;
  bit          m_post_rst = 1;
  logic [15:0] e_res;
  logic        e_neg, e_zero, e_ovf, e_err;
  int          dut_grants[$];

  function automatic void ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic ovf, output logic err);
    int sa, sb, t, sh;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b[3:0]);
    t = 0; r = 16'h0; ovf = 1'b0; err = 1'b0;
    case (op)
      4'd1: begin t = sa + sb; r = t[15:0]; ovf = (t > 32767) || (t < -32768); end
      4'd2: begin t = sa - sb; r = t[15:0]; ovf = (t > 32767) || (t < -32768); end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = ~a;
      4'd7: r = a << sh;
      4'd8: r = a >> sh;
      4'd9: begin t = sa >>> sh; r = t[15:0]; end
      default: err = 1'b1;
    endcase
  endfunction

  task automatic clear_stage();
    for (int i = 0; i < 2; i++) begin
      s_v[i] = 1'b0; s_op[i] = 4'd0; s_a[i] = 16'h0; s_b[i] = 16'h0; s_rr[i] = 1'b0;
    end
    s_rst = 1'b0;
  endtask

  // One clock cycle: drive staged inputs, check every output against the model, then advance it.
  task automatic step();
    int   w;
    logic exp_r0, exp_r1, exp_v0, exp_v1;
    @(negedge clk);
    reset      = s_rst;
    req0_valid = s_v[0]; req0_op = s_op[0]; req0_a = s_a[0]; req0_b = s_b[0]; rsp0_ready = s_rr[0];
    req1_valid = s_v[1]; req1_op = s_op[1]; req1_a = s_a[1]; req1_b = s_b[1]; rsp1_ready = s_rr[1];
    #1;
    if (s_v[0] && s_v[1]) w = m_prio;
    else if (s_v[1])      w = 1;
    else                  w = 0;
    exp_r0 = !s_rst && (m_active == 0) && s_v[0] && (w == 0);
    exp_r1 = !s_rst && (m_active == 0) && s_v[1] && (w == 1);
    exp_v0 = (m_active != 0) && (m_age >= 1) && (m_owner == 0);
    exp_v1 = (m_active != 0) && (m_age >= 1) && (m_owner == 1);
    check_eq("req0_ready", req0_ready, exp_r0);
    check_eq("req1_ready", req1_ready, exp_r1);
    check_eq("rsp0_valid", rsp0_valid, exp_v0);
    check_eq("rsp1_valid", rsp1_valid, exp_v1);
    check_eq("busy", busy, (m_active != 0));
    if (exp_v0 || exp_v1) begin
      check_eq("rsp_result", rsp_result, e_res);
      check_eq("rsp_neg", rsp_neg, e_neg);
      check_eq("rsp_zero", rsp_zero, e_zero);
      check_eq("rsp_overflow", rsp_overflow, e_ovf);
      check_eq("rsp_err", rsp_err, e_err);
    end
    if (m_post_rst) begin
      check_eq("rst_bus", {rsp_result, rsp_neg, rsp_zero, rsp_overflow, rsp_err}, 20'h0);
    end
    if (req0_ready) dut_grants.push_back(0);
    if (req1_ready) dut_grants.push_back(1);
    // Model the coming rising edge.
    m_post_rst = 0;
    if (s_rst) begin
      m_active = 0; m_prio = 0; m_post_rst = 1;
    end else if (m_active != 0) begin
      if (m_age >= 1 && s_rr[m_owner]) m_active = 0;
      else m_age++;
    end else if (exp_r0 || exp_r1) begin
      m_active = 1; m_owner = w; m_age = 0; m_prio = 1 - w;
      ref_alu(s_op[w], s_a[w], s_b[w], e_res, e_ovf, e_err);
      e_neg  = e_res[15];
      e_zero = (e_res == 16'h0);
    end
  endtask

  logic [15:0] corners[5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

  function automatic logic [15:0] rnd16();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  task automatic do_reset();
    clear_stage();
    s_rst = 1'b1; step(); step();
    s_rst = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_op = 4'd0; req0_a = 16'h0; req0_b = 16'h0; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 16'h0; req1_b = 16'h0; rsp1_ready = 1'b0;
    e_res = 16'h0; e_neg = 1'b0; e_zero = 1'b0; e_ovf = 1'b0; e_err = 1'b0;

    do_reset();

    // req0 ADD 43+25 alone.
    clear_stage();
    s_v[0] = 1'b1; s_op[0] = 4'd1; s_a[0] = 16'd43; s_b[0] = 16'd25; s_rr[0] = 1'b1;
    step();
    check_eq("add_accept", req0_ready, 1'b1);
    s_v[0] = 1'b0;
    step();
    step();
    check_eq("add_valid", rsp0_valid, 1'b1);
    check_eq("add_result", rsp_result, 16'd68);
    step();

    // req1 ADD 7FFF+7FFF: overflow and negative, only rsp1 asserts.
    clear_stage();
    s_v[1] = 1'b1; s_op[1] = 4'd1; s_a[1] = 16'h7FFF; s_b[1] = 16'h7FFF; s_rr[1] = 1'b1;
    step();
    s_v[1] = 1'b0;
    step();
    step();
    check_eq("ovf_result", rsp_result, 16'hFFFE);
    check_eq("ovf_flag", rsp_overflow, 1'b1);
    check_eq("ovf_other", rsp0_valid, 1'b0);
    step();

    // Both valid every cycle with ready high: alternating grants, one per 3 cycles.
    do_reset();
    dut_grants.delete();
    for (int i = 0; i < 2; i++) begin
      s_v[i] = 1'b1; s_op[i] = 4'd2; s_a[i] = 16'(100 * (i + 1)); s_b[i] = 16'd7; s_rr[i] = 1'b1;
    end
    for (int c = 0; c < 12; c++) step();
    check_eq("rr_count", dut_grants.size(), 4);
    for (int i = 0; i < dut_grants.size(); i++) check_eq("rr_order", dut_grants[i], i % 2);

    // Illegal opcodes 0000 and 1111.
    clear_stage(); step();
    for (int k = 0; k < 2; k++) begin
      clear_stage();
      s_v[0] = 1'b1; s_op[0] = (k == 0) ? 4'h0 : 4'hF; s_a[0] = 16'h1234; s_b[0] = 16'h0001; s_rr[0] = 1'b1;
      step();
      s_v[0] = 1'b0;
      step(); step();
      check_eq("illegal_err", rsp_err, 1'b1);
      check_eq("illegal_zero", rsp_zero, 1'b1);
      step();
    end

    // rsp0_ready held low: response stable, req1 blocked, then release.
    clear_stage();
    s_v[0] = 1'b1; s_op[0] = 4'd5; s_a[0] = 16'hA5A5; s_b[0] = 16'h0F0F;
    step();
    s_v[0] = 1'b0;
    s_v[1] = 1'b1; s_op[1] = 4'd3; s_a[1] = 16'hFFFF; s_b[1] = 16'h00F0; s_rr[1] = 1'b1;
    for (int c = 0; c < 6; c++) step();
    check_eq("stall_busy", busy, 1'b1);
    check_eq("stall_result", rsp_result, 16'hAAAA);
    s_rr[0] = 1'b1;
    step();
    step();
    check_eq("release_idle_accept", req1_ready, 1'b1);
    s_v[1] = 1'b0;
    for (int c = 0; c < 3; c++) step();

    // Reset during EXEC discards the transaction.
    clear_stage();
    s_v[0] = 1'b1; s_op[0] = 4'd1; s_a[0] = 16'd9; s_b[0] = 16'd9; s_rr[0] = 1'b1;
    step();
    s_v[0] = 1'b0; s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    step();
    check_eq("rst_exec_busy", busy, 1'b0);
    step();
    check_eq("rst_exec_novalid", rsp0_valid, 1'b0);
    s_v[1] = 1'b1; s_op[1] = 4'd1; s_a[1] = 16'd1; s_b[1] = 16'd1; s_rr[1] = 1'b1;
    step();
    s_v[1] = 1'b0;
    step(); step();
    check_eq("after_rst_add", rsp_result, 16'd2);
    step();

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        s_v[i]  = ($urandom_range(0, 1) == 1);
        s_op[i] = 4'($urandom_range(0, 15));
        s_a[i]  = rnd16();
        s_b[i]  = rnd16();
        s_rr[i] = ($urandom_range(0, 9) < 6);
      end
      s_rst = ($urandom_range(0, 59) == 0);
      step();
    end

    clear_stage();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous, active-high.
REQ-002 SHALL have requester n (n = 0,1) ports: reqn_valid  input  1  operation request.
REQ-003 reqn_op  input  4  ALU opcode.
REQ-004 reqn_a, reqn_b  input  16  operands.
REQ-005 reqn_ready  output  1  request accepted this cycle.
REQ-006 rspn_valid  output  1  response available.
REQ-007 rspn_ready  input  1  requester consumes response.
REQ-008 SHALL have shared response bus: rsp_result  output  16; rsp_neg, rsp_zero, rsp_overflow, rsp_err  output  1 each.
REQ-009 SHALL have busy  output  1: high in any state other than IDLE.

Function
REQ-010 SHALL share one alu instance (ALUOp, a, b -> result, neg, zero, overflow) between two requesters, one operation at a time.
REQ-011 FSM states: IDLE, EXEC, RESP. IDLE->EXEC on accept; EXEC->RESP unconditionally after one cycle; RESP->IDLE when owner's rspn_ready=1.
REQ-012 Accept: in IDLE, reqn_ready=1 only for the granted requester with reqn_valid=1; transfer occurs when valid and ready are both high on a clock edge.
REQ-013 Grant: single valid request wins; both valid -> round-robin, the requester not granted last wins; after reset requester 0 has priority.
REQ-014 On accept, op/a/b SHALL be registered into ALU input registers and owner id recorded; ALU output SHALL be registered at end of EXEC.
REQ-015 Latency: accept at edge N -> rspn_valid high from cycle after edge N+1 (two cycles after accept), held with stable data until rspn_ready.
REQ-016 Only the owner's rspn_valid SHALL assert; the other stays 0.
REQ-017 Legal opcodes 4'b0001..4'b1001; opcode 4'b0000 or >4'b1001 SHALL be accepted but respond rsp_result=0, rsp_zero=1, rsp_neg=0, rsp_overflow=0, rsp_err=1; legal ops give rsp_err=0 and ALU outputs unmodified.
REQ-018 rspn_ready while not owner or not in RESP SHALL be ignored.
REQ-019 Response consumed and new request pending in the same cycle: RESP->IDLE, new accept no earlier than next cycle (max one op per 3 cycles).
REQ-020 Requests may be withdrawn (valid dropped) before acceptance without effect.

Reset
REQ-021 reset SHALL force IDLE, all readys/rspn_valid/busy 0, rsp_result 0, all flags and rsp_err 0, round-robin pointer to requester 0.
REQ-022 reset mid-operation (EXEC or RESP) SHALL discard the transaction; no response emitted afterward.
REQ-023 reset SHALL take priority over every other event on the same edge.

Structure
REQ-024 Shared package alu_pkg SHALL hold ALU opcode constants (NOP, ADD, ..., 4'b1001 upper bound), FSM state encoding, data width 16.
REQ-025 Sole sub-module SHALL be the existing alu, instantiated once.

Verification
REQ-026 req0 ADD a=43 b=25 alone -> req0_ready on cycle 1, rsp0_valid two cycles later, result 68, neg=0 zero=0 overflow=0 err=0.
REQ-027 req1 ADD 16'h7FFF+16'h7FFF -> result 16'hFFFE, overflow=1, neg=1, only rsp1_valid asserts.
REQ-028 both valid every cycle, rsp ready tied high -> grants alternate 0,1,0,1 starting with 0; each completes in 3 cycles.
REQ-029 req0 op 4'b0000 and op 4'b1111 -> result 0, zero=1, err=1.
REQ-030 rsp0_ready held low 5 cycles -> rsp0_valid and data stable, req1_ready stays 0, busy=1; release -> IDLE next cycle.
REQ-031 reset asserted during EXEC -> next cycle all outputs 0, no rsp_valid; subsequent req1 ADD 1+1 returns 2.
